// File: rtl/icache_l15_miss_buffer.sv
// I$ miss buffer toward the L1.5 adapter: FIFO of line-aligned misses, one miss in flight,
// stale-on-invalidate reissue. Define ICACHE_MISS_DEDUP_EN to drop requests already queued or in flight.
module icache_l15_miss_buffer #(
  parameter int unsigned AddrWidth = 40,
  parameter int unsigned LineWidth = 512,
  parameter int unsigned Depth     = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  input  logic [AddrWidth-1:0] req_paddr_i,
  output logic                 resp_valid_o,
  output logic [LineWidth-1:0] resp_data_o,
  output logic                 inval_valid_o,
  output logic [AddrWidth-1:0] inval_addr_o,
  output logic                 miss_valid_o,
  input  logic                 miss_ready_i,
  output logic [AddrWidth-1:0] miss_paddr_o,
  input  logic                 miss_resp_valid_i,
  input  logic [LineWidth-1:0] miss_resp_data_i,
  input  logic                 l15_inval_valid_i,
  input  logic [AddrWidth-1:0] l15_inval_addr_i,
  output logic                 overflow_o,
  output logic                 busy_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned OffW = 6;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

  state_e               state_q, state_d;
  logic [AddrWidth-1:0] fifo_q [Depth];
  logic [PtrW-1:0]      rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0]      count_q;
  logic [AddrWidth-1:0] inflight_q;
  logic                 inflight_valid_q;
  logic                 stale_q;
  logic                 overflow_q;
  logic [LineWidth-1:0] data_q;
  logic                 inval_valid_q;
  logic [AddrWidth-1:0] inval_addr_q;

  logic                 full, empty, handshake, pop, push, drop_dup, inval_hit, resp_stale;
  logic [AddrWidth-1:0] req_line;
  logic                 unused_offset;

  assign req_line      = {req_paddr_i[AddrWidth-1:OffW], {OffW{1'b0}}};
  assign unused_offset = ^req_paddr_i[OffW-1:0];

  assign full      = (count_q == CntW'(Depth));
  assign empty     = (count_q == '0);
  assign handshake = (state_q == REQ) && miss_ready_i;
  // A reissue re-sends the in-flight address; only a first issue consumes the FIFO head.
  assign pop       = handshake && !inflight_valid_q;
  assign inval_hit = l15_inval_valid_i && (state_q == WAIT) &&
                     (l15_inval_addr_i[AddrWidth-1:OffW] == inflight_q[AddrWidth-1:OffW]);
  assign resp_stale = stale_q || inval_hit;

`ifdef ICACHE_MISS_DEDUP_EN
  logic [PtrW-1:0] rel_idx;
  always_comb begin
    rel_idx  = '0;
    drop_dup = inflight_valid_q &&
               (inflight_q[AddrWidth-1:OffW] == req_line[AddrWidth-1:OffW]);
    for (int unsigned i = 0; i < Depth; i++) begin
      rel_idx = PtrW'(i) - rd_ptr_q;
      if ((CntW'(rel_idx) < count_q) &&
          (fifo_q[i][AddrWidth-1:OffW] == req_line[AddrWidth-1:OffW])) begin
        drop_dup = 1'b1;
      end
    end
  end
`else
  assign drop_dup = 1'b0;
`endif

  assign push = req_valid_i && !drop_dup && (!full || pop);

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= req_line;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: ;
      endcase
      if (req_valid_i && !drop_dup && full && !pop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (!empty) state_d = REQ;
      REQ:  if (miss_ready_i) state_d = WAIT;
      WAIT: if (miss_resp_valid_i) state_d = resp_stale ? REQ : RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q          <= IDLE;
      inflight_q       <= '0;
      inflight_valid_q <= 1'b0;
      stale_q          <= 1'b0;
      data_q           <= '0;
    end else begin
      state_q <= state_d;
      if (handshake) begin
        inflight_valid_q <= 1'b1;
        stale_q          <= 1'b0;
        if (!inflight_valid_q) begin
          inflight_q <= fifo_q[rd_ptr_q];
        end
      end
      if (state_q == WAIT) begin
        if (miss_resp_valid_i) begin
          stale_q <= 1'b0;
          if (!resp_stale) begin
            data_q <= miss_resp_data_i;
          end
        end else if (inval_hit) begin
          stale_q <= 1'b1;
        end
      end
      if (state_q == RESP) begin
        inflight_valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inval_valid_q <= 1'b0;
      inval_addr_q  <= '0;
    end else begin
      inval_valid_q <= l15_inval_valid_i;
      inval_addr_q  <= l15_inval_addr_i;
    end
  end

  assign resp_valid_o  = (state_q == RESP);
  assign resp_data_o   = data_q;
  assign inval_valid_o = inval_valid_q;
  assign inval_addr_o  = inval_addr_q;
  assign miss_valid_o  = (state_q == REQ);
  assign miss_paddr_o  = (state_q != REQ) ? '0 :
                         (inflight_valid_q ? inflight_q : fifo_q[rd_ptr_q]);
  assign overflow_o    = overflow_q;
  assign busy_o        = !empty || (state_q != IDLE);

endmodule

// File: tb/tb_icache_l15_miss_buffer.sv
// Bench for icache_l15_miss_buffer: directed scenarios plus randomized traffic against a queue-based model.
module tb_icache_l15_miss_buffer;
  localparam int unsigned AW = 40;
  localparam int unsigned LW = 512;
  localparam int unsigned D  = 2;
`ifdef ICACHE_MISS_DEDUP_EN
  localparam int EXP_DEDUP_MISSES = 1;
`else
  localparam int EXP_DEDUP_MISSES = 2;
`endif

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          req_valid_i;
  logic [AW-1:0] req_paddr_i;
  logic          resp_valid_o;
  logic [LW-1:0] resp_data_o;
  logic          inval_valid_o;
  logic [AW-1:0] inval_addr_o;
  logic          miss_valid_o;
  logic          miss_ready_i;
  logic [AW-1:0] miss_paddr_o;
  logic          miss_resp_valid_i;
  logic [LW-1:0] miss_resp_data_i;
  logic          l15_inval_valid_i;
  logic [AW-1:0] l15_inval_addr_i;
  logic          overflow_o;
  logic          busy_o;

  icache_l15_miss_buffer #(.AddrWidth(AW), .LineWidth(LW), .Depth(D)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_paddr_i(req_paddr_i),
    .resp_valid_o(resp_valid_o), .resp_data_o(resp_data_o),
    .inval_valid_o(inval_valid_o), .inval_addr_o(inval_addr_o),
    .miss_valid_o(miss_valid_o), .miss_ready_i(miss_ready_i), .miss_paddr_o(miss_paddr_o),
    .miss_resp_valid_i(miss_resp_valid_i), .miss_resp_data_i(miss_resp_data_i),
    .l15_inval_valid_i(l15_inval_valid_i), .l15_inval_addr_i(l15_inval_addr_i),
    .overflow_o(overflow_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid_i       = 1'b0;
    req_paddr_i       = '0;
    miss_ready_i      = 1'b0;
    miss_resp_valid_i = 1'b0;
    miss_resp_data_i  = '0;
    l15_inval_valid_i = 1'b0;
    l15_inval_addr_i  = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_resp_valid"}, resp_valid_o, 0);
    check_eq({tag, "_resp_data"}, resp_data_o, 0);
    check_eq({tag, "_inval_valid"}, inval_valid_o, 0);
    check_eq({tag, "_inval_addr"}, inval_addr_o, 0);
    check_eq({tag, "_miss_valid"}, miss_valid_o, 0);
    check_eq({tag, "_miss_paddr"}, miss_paddr_o, 0);
    check_eq({tag, "_overflow"}, overflow_o, 0);
    check_eq({tag, "_busy"}, busy_o, 0);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_ni = 1'b0;
    repeat (2) tick();
    rst_ni = 1'b1;
    check_all_zero("rst");
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    v = '0;
    for (int i = 0; i < int'(LW / 32); i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic bit same_line(input logic [AW-1:0] a, input logic [AW-1:0] b);
    return (a >> 6) == (b >> 6);
  endfunction

  // Reference model: queue of pending line addresses plus the miss currently at the adapter.
  logic [AW-1:0] mq[$];
  logic [AW-1:0] m_inflight;
  bit            m_out, m_reissue, m_stale, m_ovf, m_resp_pend, m_inv_v;
  logic [LW-1:0] m_resp_data;
  logic [AW-1:0] m_inv_a;
  int            wait_cnt, delay, stall;

  task automatic model_clear();
    mq.delete();
    m_inflight = '0; m_out = 0; m_reissue = 0; m_stale = 0; m_ovf = 0;
    m_resp_pend = 0; m_inv_v = 0; m_inv_a = '0; m_resp_data = '0;
    wait_cnt = 0; delay = 0; stall = 0;
  endtask

  task automatic rand_cycle(input bit allow_new);
    bit            mv, hs, pop, dup, inv_hit, next_resp, allowed;
    logic [AW-1:0] line, exp_addr;
    logic [AW-1:0] base;
    base = 40'h10_0000_0000;

    check_eq("r_resp_valid", resp_valid_o, m_resp_pend);
    if (m_resp_pend) check_eq("r_resp_data", resp_data_o, m_resp_data);
    check_eq("r_inval_valid", inval_valid_o, m_inv_v);
    if (m_inv_v) check_eq("r_inval_addr", inval_addr_o, m_inv_a);
    check_eq("r_overflow", overflow_o, m_ovf);
    check_eq("r_busy", busy_o, (mq.size() != 0) || m_out || m_reissue || m_resp_pend);
    allowed = !m_out && !m_resp_pend && (m_reissue || mq.size() != 0);
    check_eq("r_miss_valid_legal", miss_valid_o && !allowed, 0);
    if (miss_valid_o && allowed) begin
      exp_addr = m_reissue ? m_inflight : mq[0];
      check_eq("r_miss_paddr", miss_paddr_o, exp_addr);
    end
    stall = (allowed && !miss_valid_o) ? stall + 1 : 0;
    check_eq("r_issue_stall", stall > 3, 0);

    req_valid_i  = allow_new && ($urandom_range(0, 3) == 0);
    req_paddr_i  = base + AW'($urandom_range(0, 7)) * 64 + AW'($urandom_range(0, 63));
    miss_ready_i = allow_new ? 1'($urandom_range(0, 1)) : 1'b1;
    miss_resp_data_i = rand_line();
    if (m_out) miss_resp_valid_i = (wait_cnt >= delay);
    else       miss_resp_valid_i = ($urandom_range(0, 15) == 0);
    l15_inval_valid_i = allow_new && ($urandom_range(0, 4) == 0);
    if (m_out && $urandom_range(0, 1) == 1)
      l15_inval_addr_i = ((m_inflight >> 6) << 6) + AW'($urandom_range(0, 63));
    else
      l15_inval_addr_i = base + AW'($urandom_range(0, 7)) * 64 + AW'($urandom_range(0, 63));

    mv = miss_valid_o;
    tick();

    hs   = mv && miss_ready_i;
    pop  = hs && !m_reissue;
    line = (req_paddr_i >> 6) << 6;
    dup  = 0;
`ifdef ICACHE_MISS_DEDUP_EN
    foreach (mq[i]) if (same_line(mq[i], line)) dup = 1;
    if ((m_out || m_reissue || m_resp_pend) && same_line(m_inflight, line)) dup = 1;
`endif
    inv_hit   = l15_inval_valid_i && m_out && same_line(l15_inval_addr_i, m_inflight);
    next_resp = 0;
    if (m_out && miss_resp_valid_i) begin
      if (m_stale || inv_hit) m_reissue = 1;
      else begin
        next_resp   = 1;
        m_resp_data = miss_resp_data_i;
      end
      m_out = 0; m_stale = 0;
    end else if (m_out) begin
      if (inv_hit) m_stale = 1;
      wait_cnt++;
    end
    if (hs) begin
      if (pop) m_inflight = mq.pop_front();
      m_reissue = 0; m_out = 1; m_stale = 0;
      wait_cnt = 0; delay = $urandom_range(0, 3);
    end
    if (req_valid_i && !dup) begin
      if (mq.size() < D) mq.push_back(line);
      else m_ovf = 1;
    end
    m_resp_pend = next_resp;
    m_inv_v     = l15_inval_valid_i;
    m_inv_a     = l15_inval_addr_i;
  endtask

  initial begin
    logic [LW-1:0] d0, d1;
    int            n_iss;
    bit            pend;
    int            guard;

    idle_inputs();
    rst_ni = 1'b0;
    #1;
    check_all_zero("por");
    do_reset();

    // Single miss, ready high
    req_valid_i = 1; req_paddr_i = 40'h80_0000_0044; miss_ready_i = 1;
    tick(); req_valid_i = 0;
    check_eq("a_idle_mv", miss_valid_o, 0);
    check_eq("a_idle_busy", busy_o, 1);
    tick();
    check_eq("a_req_mv", miss_valid_o, 1);
    check_eq("a_req_paddr", miss_paddr_o, 40'h80_0000_0040);
    tick();
    check_eq("a_wait_mv", miss_valid_o, 0);
    d0 = {16{32'hA5A5_A5A5}};
    miss_resp_valid_i = 1; miss_resp_data_i = d0;
    tick(); miss_resp_valid_i = 0;
    check_eq("a_resp_valid", resp_valid_o, 1);
    check_eq("a_resp_data", resp_data_o, d0);
    tick();
    check_eq("a_resp_pulse", resp_valid_o, 0);
    check_eq("a_done_busy", busy_o, 0);

    // Overflow with Depth=2 and no ready
    do_reset();
    for (int i = 0; i < 3; i++) begin
      req_valid_i = 1; req_paddr_i = 40'h100 + AW'(i) * 40'h40;
      tick();
    end
    req_valid_i = 0;
    check_eq("b_overflow", overflow_o, 1);
    check_eq("b_busy", busy_o, 1);
    check_eq("b_head", miss_paddr_o, 40'h100);
    miss_ready_i = 1;
    tick();
    miss_resp_valid_i = 1; miss_resp_data_i = rand_line();
    tick(); miss_resp_valid_i = 0;
    tick(); tick();
    check_eq("b_second", miss_paddr_o, 40'h140);
    tick();
    miss_resp_valid_i = 1;
    tick(); miss_resp_valid_i = 0;
    tick(); tick(); tick();
    check_eq("b_third_dropped", miss_valid_o, 0);
    check_eq("b_drained_busy", busy_o, 0);
    check_eq("b_sticky_ovf", overflow_o, 1);

    // Invalidation in WAIT, then response: reissue
    do_reset();
    miss_ready_i = 1;
    req_valid_i = 1; req_paddr_i = 40'h3000;
    tick(); req_valid_i = 0;
    tick(); tick();
    l15_inval_valid_i = 1; l15_inval_addr_i = 40'h3020;
    tick(); l15_inval_valid_i = 0;
    check_eq("c_inval_fwd", inval_valid_o, 1);
    check_eq("c_inval_addr", inval_addr_o, 40'h3020);
    miss_resp_valid_i = 1; miss_resp_data_i = rand_line();
    tick(); miss_resp_valid_i = 0;
    check_eq("c_stale_resp", resp_valid_o, 0);
    check_eq("c_reissue_mv", miss_valid_o, 1);
    check_eq("c_reissue_addr", miss_paddr_o, 40'h3000);
    tick();
    d1 = rand_line();
    miss_resp_valid_i = 1; miss_resp_data_i = d1;
    tick(); miss_resp_valid_i = 0;
    check_eq("c_resp2_valid", resp_valid_o, 1);
    check_eq("c_resp2_data", resp_data_o, d1);
    tick();
    check_eq("c_done_busy", busy_o, 0);

    // Invalidation and response in the same cycle
    do_reset();
    miss_ready_i = 1;
    req_valid_i = 1; req_paddr_i = 40'h1000;
    tick(); req_valid_i = 0;
    tick(); tick();
    l15_inval_valid_i = 1; l15_inval_addr_i = 40'h1000;
    miss_resp_valid_i = 1; miss_resp_data_i = rand_line();
    tick(); l15_inval_valid_i = 0; miss_resp_valid_i = 0;
    check_eq("d_inval_fwd", inval_valid_o, 1);
    check_eq("d_inval_addr", inval_addr_o, 40'h1000);
    check_eq("d_resp_dropped", resp_valid_o, 0);
    check_eq("d_reissue_addr", miss_paddr_o, 40'h1000);
    tick();
    miss_resp_valid_i = 1;
    tick(); miss_resp_valid_i = 0;
    check_eq("d_resp2", resp_valid_o, 1);
    tick();

    // Two requests in one line
    do_reset();
    miss_ready_i = 1;
    req_valid_i = 1; req_paddr_i = 40'h2000;
    tick(); req_paddr_i = 40'h2010;
    tick(); req_valid_i = 0;
    n_iss = 0; pend = 0;
    for (int i = 0; i < 30; i++) begin
      miss_resp_valid_i = pend;
      miss_resp_data_i  = rand_line();
      if (miss_valid_o) n_iss++;
      pend = miss_valid_o;
      tick();
    end
    miss_resp_valid_i = 0;
    check_eq("e_miss_count", n_iss, EXP_DEDUP_MISSES);
    check_eq("e_busy", busy_o, 0);
    check_eq("e_overflow", overflow_o, 0);

    // Reset during WAIT, response after release
    do_reset();
    miss_ready_i = 1;
    req_valid_i = 1; req_paddr_i = 40'h5000;
    tick(); req_valid_i = 0;
    tick(); tick();
    #2 rst_ni = 1'b0;
    #1 check_all_zero("f_async");
    tick();
    rst_ni = 1'b1;
    miss_resp_valid_i = 1; miss_resp_data_i = rand_line();
    tick(); miss_resp_valid_i = 0;
    for (int i = 0; i < 4; i++) begin
      check_all_zero("f_post");
      tick();
    end

    // Randomized traffic against the model
    do_reset();
    model_clear();
    for (int i = 0; i < 3000; i++) rand_cycle(1'b1);
    guard = 0;
    while ((mq.size() != 0 || m_out || m_reissue || m_resp_pend) && guard < 200) begin
      rand_cycle(1'b0);
      guard++;
    end
    check_eq("r_drain_bound", guard < 200, 1);
    rand_cycle(1'b0);
    check_eq("r_final_busy", busy_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/icache_l15_miss_buffer.md
ICACHE_L15_MISS_BUFFER -- requirements
Module: icache_l15_miss_buffer

Interface
REQ-001: Parameter AddrWidth, default 40, physical address width.
REQ-002: Parameter LineWidth, default 512, I$ line width in bits.
REQ-003: Parameter Depth, default 2, miss FIFO entries (power of two, >=2).
REQ-004: Ports SHALL be: clk_i in 1 clock; rst_ni in 1 async active-low reset; one clock, reset asynchronous and active-low.
REQ-005: req_valid_i in 1, core I$ miss request (no ready, single-cycle pulse); req_paddr_i in AddrWidth, miss address.
REQ-006: resp_valid_o out 1, line return to core; resp_data_o out LineWidth, line data.
REQ-007: inval_valid_o out 1, invalidation to core; inval_addr_o out AddrWidth, invalidated address.
REQ-008: miss_valid_o out 1; miss_ready_i in 1; miss_paddr_o out AddrWidth -- request to L1.5 adapter.
REQ-009: miss_resp_valid_i in 1; miss_resp_data_i in LineWidth -- adapter line return.
REQ-010: l15_inval_valid_i in 1; l15_inval_addr_i in AddrWidth -- adapter invalidation.
REQ-011: overflow_o out 1, sticky drop flag; busy_o out 1, FIFO non-empty or FSM not IDLE.

Function
REQ-012: Addresses SHALL be line-aligned on enqueue (bits [5:0] forced 0); all compares use bits [AddrWidth-1:6].
REQ-013: req_valid_i with FIFO not full SHALL enqueue at tail same edge; FIFO full and no same-cycle pop -> request dropped, overflow_o set 1 until reset.
REQ-014: Enqueue and pop in the same cycle while full SHALL be accepted (occupancy unchanged); pointers wrap modulo Depth.
REQ-015: FSM states IDLE, REQ, WAIT, RESP; exactly one miss outstanding.
REQ-016: IDLE: FIFO non-empty -> REQ next cycle; else stay.
REQ-017: REQ: miss_valid_o=1, miss_paddr_o=head; miss_valid_o/paddr stable until miss_ready_i; on handshake pop head into in-flight register, -> WAIT.
REQ-018: WAIT: miss_resp_valid_i with stale=0 -> capture data, -> RESP; with stale=1 -> discard data, clear stale, -> REQ reissuing in-flight address (FIFO not popped).
REQ-019: RESP: resp_valid_o=1 for exactly one cycle with captured data, -> IDLE; response latency = 1 cycle after miss_resp_valid_i.
REQ-020: l15_inval_valid_i SHALL be forwarded registered: inval_valid_o/inval_addr_o one cycle later, every occurrence, no back-pressure.
REQ-021: l15_inval_valid_i in WAIT with line matching in-flight line SHALL set stale; same-cycle miss_resp_valid_i counts as stale (invalidation wins).
REQ-022: Invalidations do not modify FIFO entries.
REQ-023: miss_resp_valid_i outside WAIT SHALL be ignored.

Reset
REQ-024: rst_ni low SHALL asynchronously clear FIFO pointers/count, in-flight valid, stale, overflow_o, FSM to IDLE; all outputs 0 (resp_data_o 0).
REQ-025: Reset mid-transaction SHALL discard pending and in-flight misses; no response generated after release.
REQ-026: First enqueue possible on first rising edge after rst_ni deassertion.

Configuration
REQ-027: Macro ICACHE_MISS_DEDUP_EN defined: req_valid_i whose line matches a valid FIFO entry or the in-flight line (REQ/WAIT/RESP) SHALL be dropped silently, overflow_o unaffected.
REQ-028: Macro undefined: every request enqueued per REQ-013, no comparison logic.

Verification
REQ-029: Single miss 0x80_0000_0044, miss_ready_i=1 -> miss_paddr_o=0x80_0000_0040 two cycles after pulse; data 0xA5.. returned -> resp_valid_o one cycle later, one pulse.
REQ-030: Depth=2, three pulses with miss_ready_i=0 -> two held, third dropped, overflow_o=1, busy_o=1.
REQ-031: In WAIT, inval on in-flight line, then response -> resp_valid_o stays 0, request for same address reissued; second response delivered.
REQ-032: Inval 0x1000 and response same cycle in WAIT on line 0x1000 -> inval_valid_o next cycle, response discarded, reissue.
REQ-033: DEDUP_EN: two pulses to 0x2000 and 0x2010 -> one miss issued; undefined -> two misses issued.
REQ-034: rst_ni asserted during WAIT, response arrives after release -> no resp_valid_o, all outputs 0.
